// File: rtl/fu_alu_cluster_if.sv
// Issue/writeback bundle between RCU issue, the ALU cluster and ROB/PRF/pc_gen.
// Lane i occupies slice [i*W +: W] of every packed per-lane field.
interface fu_alu_cluster_if #(
    parameter int NUM_ALU            = 2,
    parameter int XLEN               = 64,
    parameter int ROB_INDEX_WIDTH    = 4,
    parameter int PHY_REG_ADDR_WIDTH = 6,
    parameter int VADDR_LEN          = 39,
    parameter int ECAUSE_WIDTH       = 4
);
    logic                                    stall_i;
    logic                                    flush_i;
    logic [ROB_INDEX_WIDTH-1:0]              rob_head_i;
    logic [NUM_ALU-1:0]                      issue_valid_i;
    logic [NUM_ALU-1:0]                      issue_ready_o;
    logic [NUM_ALU*XLEN-1:0]                 op_a_i;
    logic [NUM_ALU*XLEN-1:0]                 op_b_i;
    logic [NUM_ALU*XLEN-1:0]                 cmp_a_i;
    logic [NUM_ALU*XLEN-1:0]                 cmp_b_i;
    logic [NUM_ALU*3-1:0]                    alu_func_i;
    logic [NUM_ALU-1:0]                      alu_mod_i;
    logic [NUM_ALU-1:0]                      half_i;
    logic [NUM_ALU*3-1:0]                    cmp_func_i;
    logic [NUM_ALU-1:0]                      branch_i;
    logic [NUM_ALU-1:0]                      jump_i;
    logic [NUM_ALU*VADDR_LEN-1:0]            pc_i;
    logic [NUM_ALU*VADDR_LEN-1:0]            next_pc_i;
    logic [NUM_ALU*ROB_INDEX_WIDTH-1:0]      rob_index_i;
    logic [NUM_ALU*PHY_REG_ADDR_WIDTH-1:0]   rd_addr_i;
    logic [NUM_ALU-1:0]                      illegal_i;
    logic [NUM_ALU*ECAUSE_WIDTH-1:0]         ecause_i;
    logic [NUM_ALU-1:0]                      done_o;
    logic [NUM_ALU-1:0]                      wb_valid_o;
    logic [NUM_ALU*ROB_INDEX_WIDTH-1:0]      wb_rob_index_o;
    logic [NUM_ALU*PHY_REG_ADDR_WIDTH-1:0]   wb_rd_addr_o;
    logic [NUM_ALU*XLEN-1:0]                 wb_data_o;
    logic                                    redirect_valid_o;
    logic                                    redirect_taken_o;
    logic [VADDR_LEN-1:0]                    redirect_pc_o;
    logic [ROB_INDEX_WIDTH-1:0]              redirect_rob_index_o;
    logic                                    exc_valid_o;
    logic [ECAUSE_WIDTH-1:0]                 exc_cause_o;
    logic [ROB_INDEX_WIDTH-1:0]              exc_rob_index_o;

    modport master (
        output stall_i, flush_i, rob_head_i, issue_valid_i, op_a_i, op_b_i, cmp_a_i, cmp_b_i,
               alu_func_i, alu_mod_i, half_i, cmp_func_i, branch_i, jump_i, pc_i, next_pc_i,
               rob_index_i, rd_addr_i, illegal_i, ecause_i,
        input  issue_ready_o, done_o, wb_valid_o, wb_rob_index_o, wb_rd_addr_o, wb_data_o,
               redirect_valid_o, redirect_taken_o, redirect_pc_o, redirect_rob_index_o,
               exc_valid_o, exc_cause_o, exc_rob_index_o
    );

    modport slave (
        input  stall_i, flush_i, rob_head_i, issue_valid_i, op_a_i, op_b_i, cmp_a_i, cmp_b_i,
               alu_func_i, alu_mod_i, half_i, cmp_func_i, branch_i, jump_i, pc_i, next_pc_i,
               rob_index_i, rd_addr_i, illegal_i, ecause_i,
        output issue_ready_o, done_o, wb_valid_o, wb_rob_index_o, wb_rd_addr_o, wb_data_o,
               redirect_valid_o, redirect_taken_o, redirect_pc_o, redirect_rob_index_o,
               exc_valid_o, exc_cause_o, exc_rob_index_o
    );
endinterface

// File: rtl/fu_alu_cluster.sv
// Multi-lane single-cycle integer ALU/branch cluster with oldest-first redirect
// and exception selection; an exception blocks issue until the next flush.
module fu_alu_cluster #(
    parameter int NUM_ALU            = 2,
    parameter int XLEN               = 64,
    parameter int ROB_INDEX_WIDTH    = 4,
    parameter int PHY_REG_ADDR_WIDTH = 6,
    parameter int VADDR_LEN          = 39,
    parameter int ECAUSE_WIDTH       = 4
) (
    input logic          clk,
    input logic          rstn,
    fu_alu_cluster_if.slave bus
);
    localparam int N    = NUM_ALU;
    localparam int RW   = ROB_INDEX_WIDTH;
    localparam int PRW  = PHY_REG_ADDR_WIDTH;
    localparam int VA   = VADDR_LEN;
    localparam int ECW  = ECAUSE_WIDTH;
    localparam int SELW = (N > 1) ? $clog2(N) : 1;

    function automatic logic [XLEN-1:0] alu_calc(input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                                                 input logic [2:0] func, input logic mod, input logic half);
        logic signed [XLEN-1:0] sa, sb;
        logic [XLEN-1:0]        r, sra_r;
        logic signed [31:0]     sa_w, sb_w;
        logic [31:0]            a_w, b_w, r_w, sra_w;
        logic [5:0]             sh;
        sa    = a;
        sb    = b;
        a_w   = a[31:0];
        b_w   = b[31:0];
        sa_w  = a[31:0];
        sb_w  = b[31:0];
        sh    = half ? {1'b0, b[4:0]} : b[5:0];
        sra_r = sa >>> sh;
        sra_w = sa_w >>> sh[4:0];
        case (func)
            3'b000:  r = mod ? a - b : a + b;
            3'b001:  r = a << sh;
            3'b010:  r = {{(XLEN-1){1'b0}}, sa < sb};
            3'b011:  r = {{(XLEN-1){1'b0}}, a < b};
            3'b100:  r = a ^ b;
            3'b101:  r = mod ? sra_r : a >> sh;
            3'b110:  r = a | b;
            default: r = a & b;
        endcase
        case (func)
            3'b000:  r_w = mod ? a_w - b_w : a_w + b_w;
            3'b001:  r_w = a_w << sh[4:0];
            3'b010:  r_w = {31'b0, sa_w < sb_w};
            3'b011:  r_w = {31'b0, a_w < b_w};
            3'b100:  r_w = a_w ^ b_w;
            3'b101:  r_w = mod ? sra_w : a_w >> sh[4:0];
            3'b110:  r_w = a_w | b_w;
            default: r_w = a_w & b_w;
        endcase
        return half ? {{(XLEN-32){r_w[31]}}, r_w} : r;
    endfunction

    function automatic logic br_cmp(input logic [XLEN-1:0] a, input logic [XLEN-1:0] b, input logic [2:0] f);
        case (f)
            3'b000:  return a == b;
            3'b001:  return a != b;
            3'b100:  return $signed(a) < $signed(b);
            3'b101:  return $signed(a) >= $signed(b);
            3'b110:  return a < b;
            3'b111:  return a >= b;
            default: return 1'b0;
        endcase
    endfunction

    logic [N-1:0]    taken_p0, acc_p0;
    logic [XLEN-1:0] data_p0 [N];
    logic [VA-1:0]   rpc_p0  [N];

    logic [N-1:0]    vld_p1, illegal_p1, branch_p1, jump_p1, taken_p1;
    logic [XLEN-1:0] data_p1  [N];
    logic [VA-1:0]   rpc_p1   [N];
    logic [RW-1:0]   rob_p1   [N];
    logic [PRW-1:0]  rd_p1    [N];
    logic [ECW-1:0]  cause_p1 [N];
    logic [RW-1:0]   age_p1   [N];
    logic            sticky;
    logic            rdy;

    logic            rd_found, ex_found;
    logic [SELW-1:0] rd_sel, ex_sel;
    logic [RW-1:0]   rd_age, ex_age;

    assign rdy                = ~bus.stall_i & ~sticky & ~ex_found & ~bus.flush_i;
    assign bus.issue_ready_o  = {N{rdy}};
    assign acc_p0             = bus.issue_valid_i & {N{rdy}};

    // p0: per-lane execute on the issue operands
    for (genvar g = 0; g < N; g++) begin : g_lane
        logic [XLEN-1:0] a, b, ca, cb;
        logic [VA-1:0]   npc, tgt;
        assign a   = bus.op_a_i[g*XLEN +: XLEN];
        assign b   = bus.op_b_i[g*XLEN +: XLEN];
        assign ca  = bus.cmp_a_i[g*XLEN +: XLEN];
        assign cb  = bus.cmp_b_i[g*XLEN +: XLEN];
        assign npc = bus.next_pc_i[g*VA +: VA];
        assign tgt = a[VA-1:0] + b[VA-1:0];

        assign taken_p0[g] = bus.jump_i[g] | br_cmp(ca, cb, bus.cmp_func_i[g*3 +: 3]);
        assign data_p0[g]  = bus.jump_i[g] ? XLEN'(npc)
                           : alu_calc(a, b, bus.alu_func_i[g*3 +: 3], bus.alu_mod_i[g], bus.half_i[g]);
        assign rpc_p0[g]   = taken_p0[g] ? tgt : npc;

        assign age_p1[g]                     = rob_p1[g] - bus.rob_head_i;
        assign bus.done_o[g]                 = vld_p1[g];
        assign bus.wb_valid_o[g]             = vld_p1[g] & ~illegal_p1[g] & (~branch_p1[g] | jump_p1[g]);
        assign bus.wb_rob_index_o[g*RW +: RW] = rob_p1[g];
        assign bus.wb_rd_addr_o[g*PRW +: PRW] = rd_p1[g];
        assign bus.wb_data_o[g*XLEN +: XLEN] = data_p1[g];
    end

    // p1: lane result registers
    always_ff @(posedge clk) begin
        if (!rstn) begin
            vld_p1     <= '0;
            illegal_p1 <= '0;
            branch_p1  <= '0;
            jump_p1    <= '0;
            taken_p1   <= '0;
            sticky     <= 1'b0;
            for (int i = 0; i < N; i++) begin
                data_p1[i]  <= '0;
                rpc_p1[i]   <= '0;
                rob_p1[i]   <= '0;
                rd_p1[i]    <= '0;
                cause_p1[i] <= '0;
            end
        end else if (bus.flush_i) begin
            vld_p1 <= '0;
            sticky <= 1'b0;
        end else if (!bus.stall_i) begin
            vld_p1     <= acc_p0;
            illegal_p1 <= bus.illegal_i;
            branch_p1  <= bus.branch_i;
            jump_p1    <= bus.jump_i;
            taken_p1   <= taken_p0;
            for (int i = 0; i < N; i++) begin
                data_p1[i]  <= data_p0[i];
                rpc_p1[i]   <= rpc_p0[i];
                rob_p1[i]   <= bus.rob_index_i[i*RW +: RW];
                rd_p1[i]    <= bus.rd_addr_i[i*PRW +: PRW];
                cause_p1[i] <= bus.ecause_i[i*ECW +: ECW];
            end
            if (|(acc_p0 & bus.illegal_i)) sticky <= 1'b1;
        end
    end

    // Oldest-first selection; strict compare lets the lower lane win a tie.
    always_comb begin
        rd_found = 1'b0;
        rd_sel   = '0;
        rd_age   = '0;
        ex_found = 1'b0;
        ex_sel   = '0;
        ex_age   = '0;
        for (int i = 0; i < N; i++) begin
            if (vld_p1[i] && branch_p1[i] && !illegal_p1[i] && (!rd_found || age_p1[i] < rd_age)) begin
                rd_found = 1'b1;
                rd_sel   = SELW'(i);
                rd_age   = age_p1[i];
            end
            if (vld_p1[i] && illegal_p1[i] && (!ex_found || age_p1[i] < ex_age)) begin
                ex_found = 1'b1;
                ex_sel   = SELW'(i);
                ex_age   = age_p1[i];
            end
        end
    end

    assign bus.redirect_valid_o     = rd_found;
    assign bus.redirect_taken_o     = rd_found & taken_p1[rd_sel];
    assign bus.redirect_pc_o        = rd_found ? rpc_p1[rd_sel] : '0;
    assign bus.redirect_rob_index_o = rd_found ? rob_p1[rd_sel] : '0;
    assign bus.exc_valid_o          = ex_found;
    assign bus.exc_cause_o          = ex_found ? cause_p1[ex_sel] : '0;
    assign bus.exc_rob_index_o      = ex_found ? rob_p1[ex_sel] : '0;
endmodule
